snake_tick_gen: RTL

SNAKE_TICK_GEN -- requirements
Module: snake_tick_gen

---
 rtl/snake_tick_gen.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/snake_tick_gen.sv
// -----------------------------------------------------------------------------
// snake_tick_gen
//   Turns the video raster position into one frame pulse per frame and divides
//   those frames down into a snake-advance pulse. The divide ratio (period)
//   starts at START_PERIOD. Each speed_up shortens it by STEP, down to
//   MIN_PERIOD. A small IDLE/RUN/PAUSE machine gates the counting.
//
// Ports
//   clk            in   system clock, rising edge
//   reset          in   asynchronous active-high reset
//   x_pos, y_pos   in   current raster position (BIT bits each)
//   start          in   pulse: IDLE->RUN, PAUSE->RUN
//   pause          in   pulse: RUN<->PAUSE toggle
//   restart        in   pulse: back to IDLE, period/level reloaded
//   speed_up       in   pulse: shorten period (ignored in IDLE)
//   update_trigger out  one-cycle snake-advance pulse
//   frame_tick     out  one-cycle pulse per frame
//   period         out  current frames-per-update (CNT_W bits)
//   level          out  count of effective speed-ups, saturating (CNT_W bits)
//   running        out  high while in RUN
//
// States
//   state | meaning
//   IDLE  | waiting for start, frame counter held at zero
//   RUN   | counting frames, update_trigger on terminal count
//   PAUSE | frame counter frozen, no update_trigger
// -----------------------------------------------------------------------------
module snake_tick_gen #(
  parameter int BIT          = 10,
  parameter int V_SYNC_COUNT = 490,
  parameter int H_SYNC_COUNT = 656,
  parameter int CNT_W        = 8,
  parameter int START_PERIOD = 10,
  parameter int MIN_PERIOD   = 2,
  parameter int STEP         = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [BIT-1:0]   x_pos,
  input  logic [BIT-1:0]   y_pos,
  input  logic             start,
  input  logic             pause,
  input  logic             restart,
  input  logic             speed_up,
  output logic             update_trigger,
  output logic             frame_tick,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] level,
  output logic             running
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [BIT-1:0]   X_MATCH   = BIT'(H_SYNC_COUNT);
  localparam logic [BIT-1:0]   Y_MATCH   = BIT'(V_SYNC_COUNT);
  localparam logic [CNT_W-1:0] START_P   = CNT_W'(START_PERIOD);
  localparam logic [CNT_W-1:0] MIN_P     = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] STEP_P    = CNT_W'(STEP);
  localparam logic [31:0]      STEP_32   = 32'(STEP);
  localparam logic [CNT_W-1:0] LEVEL_MAX = '1;

  state_t           state;
  state_t           state_nxt;
  logic             match;
  logic             match_q;
  logic             frame_ev;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] period_m1;
  logic             term_cnt;
  logic             count_ev;
  logic             trig_nxt;
  logic             speed_ev;
  logic             can_dec;
  logic [CNT_W-1:0] slack;
  logic [CNT_W-1:0] period_dec;
  logic [CNT_W-1:0] period_nxt;
  logic [CNT_W-1:0] level_nxt;

  // Frame detection: rising edge of the raster match, so a match held for
  // several cycles still yields a single event.
  assign match    = (y_pos == Y_MATCH) && (x_pos == X_MATCH);
  assign frame_ev = match && !match_q;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: restart beats start beats pause
  always_comb begin
    state_nxt = state;
    if (restart) begin
      state_nxt = IDLE;
    end else if (start) begin
      state_nxt = RUN;
    end else if (pause) begin
      case (state)
        RUN:     state_nxt = PAUSE;
        PAUSE:   state_nxt = RUN;
        default: state_nxt = state;
      endcase
    end
  end

  assign running = (state == RUN);

  // Terminal count uses >= so that a speed-up that leaves cnt beyond the new
  // period fires on the next frame instead of wrapping through 2^CNT_W.
  // period never drops below 1, so period-1 cannot underflow.
  assign period_m1 = period - 1'b1;
  assign term_cnt  = (cnt >= period_m1);
  assign count_ev  = (state == RUN) && frame_ev;

  always_comb begin
    cnt_nxt  = cnt;
    trig_nxt = 1'b0;
    if (restart || (state == IDLE)) begin
      cnt_nxt = '0;
    end else if (count_ev) begin
      if (term_cnt) begin
        cnt_nxt  = '0;
        trig_nxt = 1'b1;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  // Speed-up: slack is only meaningful when period > MIN_P. If slack exceeds
  // STEP, STEP is known to fit in CNT_W bits, so the subtraction is exact.
  assign speed_ev   = speed_up && (state != IDLE) && !restart;
  assign can_dec    = (period > MIN_P);
  assign slack      = period - MIN_P;
  assign period_dec = (32'(slack) > STEP_32) ? (period - STEP_P) : MIN_P;

  always_comb begin
    period_nxt = period;
    level_nxt  = level;
    if (restart) begin
      period_nxt = START_P;
      level_nxt  = '0;
    end else if (speed_ev && can_dec) begin
      period_nxt = period_dec;
      if (level != LEVEL_MAX) begin
        level_nxt = level + 1'b1;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match_q        <= 1'b0;
      frame_tick     <= 1'b0;
      update_trigger <= 1'b0;
      cnt            <= '0;
      period         <= START_P;
      level          <= '0;
    end else begin
      match_q        <= match;
      frame_tick     <= frame_ev;
      update_trigger <= trig_nxt;
      cnt            <= cnt_nxt;
      period         <= period_nxt;
      level          <= level_nxt;
    end
  end

endmodule
